// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one MIG command/write/read FIFO set among NUM_REQ requesters, one burst at a time.
// Optional MEM_ARB_FIXED_PRIORITY_EN: requester 0 (host path) wins whenever it asks; 1..NUM_REQ-1 stay round-robin.

module mem_port_arb_lane (
  input  logic pick_hit,
  input  logic can_pick,
  input  logic gnt_hit,
  input  logic in_write,
  input  logic in_read,
  input  logic mem_wr_ready,
  input  logic mem_rd_enable,
  output logic cmd_ready,
  output logic wr_ready,
  output logic rd_enable
);
  assign cmd_ready = can_pick & pick_hit;
  assign wr_ready  = in_write & gnt_hit & mem_wr_ready;
  assign rd_enable = in_read & gnt_hit & mem_rd_enable;
endmodule

module mem_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MEM_WIDTH = 32,
  parameter int CMD_WIDTH = 65,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_cmd_enable,
  output logic [NUM_REQ-1:0]           req_cmd_ready,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd_data,
  input  logic [NUM_REQ-1:0]           req_wr_enable,
  output logic [NUM_REQ-1:0]           req_wr_ready,
  input  logic [NUM_REQ*MEM_WIDTH-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]           req_rd_enable,
  input  logic [NUM_REQ-1:0]           req_rd_ready,
  output logic [MEM_WIDTH-1:0]         req_rd_data,
  output logic                         mem_cmd_enable,
  input  logic                         mem_cmd_ready,
  output logic [CMD_WIDTH-1:0]         mem_cmd_data,
  output logic                         mem_wr_enable,
  input  logic                         mem_wr_ready,
  output logic [MEM_WIDTH-1:0]         mem_wr_data,
  input  logic                         mem_rd_enable,
  output logic                         mem_rd_ready,
  input  logic [MEM_WIDTH-1:0]         mem_rd_data,
  output logic                         busy,
  output logic [GW-1:0]                grant_id
);

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, READ} state_t;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  localparam bit HOST_PRI = 1'b1;
`else
  localparam bit HOST_PRI = 1'b0;
`endif

  state_t        st, st_nxt;
  cmd_t          cmd_q, sel_cmd;
  logic [GW-1:0] rr_ptr, rr_nxt, pick;
  logic [GW:0]   rr_r;
  logic          pick_vld, host_win, cmd_take, can_pick;
  logic          cmd_xfer, data_xfer, last_word;
  logic [31:0]   word_count, wc_inc;

  // Scan ptr, ptr+1, ... mod NUM_REQ; the lowest offset with a request wins.
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] en,
                                          input logic [GW-1:0] ptr,
                                          input logic skip0);
    logic [GW:0]   r;
    logic [GW-1:0] ci;
    int            c;
    r = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      c  = (int'(ptr) + k) % NUM_REQ;
      ci = GW'(c);
      if (en[ci] && !(skip0 && ci == '0)) r = {1'b1, ci};
    end
    return r;
  endfunction

  assign rr_r     = rr_pick(req_cmd_enable, rr_ptr, HOST_PRI);
  assign host_win = HOST_PRI && req_cmd_enable[0];
  assign pick_vld = host_win || rr_r[GW];
  assign pick     = host_win ? '0 : rr_r[GW-1:0];
  assign rr_nxt   = (pick == GW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
  assign sel_cmd  = req_cmd_data[pick*CMD_WIDTH +: CMD_WIDTH];

  assign cmd_take  = (st == IDLE) && pick_vld;
  // Gated by reset so the grant pulse is also forced low while reset is held.
  assign can_pick  = reset_n && cmd_take;
  assign cmd_xfer  = (st == ISSUE) && mem_cmd_ready;
  assign data_xfer = ((st == WRITE) && mem_wr_enable && mem_wr_ready) ||
                     ((st == READ)  && mem_rd_enable && mem_rd_ready);
  assign wc_inc    = word_count + 32'd1;
  assign last_word = (wc_inc == cmd_q.len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:  if (pick_vld && sel_cmd.len != 32'd0) st_nxt = ISSUE;
      ISSUE: if (mem_cmd_ready) st_nxt = cmd_q.rnw ? READ : WRITE;
      WRITE: if (data_xfer && last_word) st_nxt = IDLE;
      READ:  if (data_xfer && last_word) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      word_count <= '0;
    end else begin
      if (cmd_take) begin
        cmd_q    <= sel_cmd;
        grant_id <= pick;
        // In host-priority mode a host grant leaves the 1..N-1 rotation untouched.
        if (!host_win) rr_ptr <= rr_nxt;
      end
      if (cmd_xfer)       word_count <= '0;
      else if (data_xfer) word_count <= wc_inc;
    end
  end

  always_comb begin
    mem_cmd_enable = 1'b0;
    mem_wr_enable  = 1'b0;
    mem_wr_data    = '0;
    mem_rd_ready   = 1'b0;
    req_rd_data    = '0;
    unique case (st)
      ISSUE: mem_cmd_enable = 1'b1;
      WRITE: begin
        mem_wr_enable = req_wr_enable[grant_id];
        mem_wr_data   = req_wr_data[grant_id*MEM_WIDTH +: MEM_WIDTH];
      end
      READ: begin
        mem_rd_ready = req_rd_ready[grant_id];
        req_rd_data  = mem_rd_data;
      end
      default: ;
    endcase
  end

  assign mem_cmd_data = cmd_q;
  assign busy         = (st != IDLE);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mem_port_arb_lane u_lane (
      .pick_hit      (pick == GW'(i)),
      .can_pick      (can_pick),
      .gnt_hit       (grant_id == GW'(i)),
      .in_write      (st == WRITE),
      .in_read       (st == READ),
      .mem_wr_ready  (mem_wr_ready),
      .mem_rd_enable (mem_rd_enable),
      .cmd_ready     (req_cmd_ready[i]),
      .wr_ready      (req_wr_ready[i]),
      .rd_enable     (req_rd_enable[i])
    );
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: writes, reads, round-robin order, backpressure, zero-length, reset abort.
// Expected grant order in test_priority depends on MEM_ARB_FIXED_PRIORITY_EN.

module tb_mem_port_arbiter;
  localparam int N = 4, MW = 32, CW = 65;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_cmd_enable = '0, req_cmd_ready;
  logic [N*CW-1:0] req_cmd_data = '0;
  logic [N-1:0]    req_wr_enable = '0, req_wr_ready;
  logic [N*MW-1:0] req_wr_data = '0;
  logic [N-1:0]    req_rd_enable, req_rd_ready = '0;
  logic [MW-1:0]   req_rd_data;
  logic            mem_cmd_enable, mem_cmd_ready = 1'b1;
  logic [CW-1:0]   mem_cmd_data;
  logic            mem_wr_enable, mem_wr_ready = 1'b1;
  logic [MW-1:0]   mem_wr_data;
  logic            mem_rd_enable = 1'b0, mem_rd_ready;
  logic [MW-1:0]   mem_rd_data = '0;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .MEM_WIDTH(MW), .CMD_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_cmd_enable(req_cmd_enable), .req_cmd_ready(req_cmd_ready), .req_cmd_data(req_cmd_data),
    .req_wr_enable(req_wr_enable), .req_wr_ready(req_wr_ready), .req_wr_data(req_wr_data),
    .req_rd_enable(req_rd_enable), .req_rd_ready(req_rd_ready), .req_rd_data(req_rd_data),
    .mem_cmd_enable(mem_cmd_enable), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_data(mem_cmd_data),
    .mem_wr_enable(mem_wr_enable), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .mem_rd_enable(mem_rd_enable), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory side: stores write words at the command address, counts write transfers.
  logic [31:0] mem_img [0:255];
  logic [7:0]  wr_addr = '0;
  int          wr_count = 0;
  always @(posedge clk) begin
    if (mem_cmd_enable && mem_cmd_ready) wr_addr <= mem_cmd_data[39:32];
    if (mem_wr_enable && mem_wr_ready) begin
      mem_img[wr_addr] <= mem_wr_data;
      wr_addr  <= wr_addr + 8'd1;
      wr_count <= wr_count + 1;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic rnw, input logic [31:0] addr, input logic [31:0] len);
    req_cmd_data[i*CW +: CW] = {rnw, addr, len};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 32'h0, 32'd1);
    req_cmd_enable = '1;
    cyc(); cyc(); #1;
    checks++; if (req_cmd_ready !== '0) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 0000", req_cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({mem_cmd_enable, mem_cmd_data} !== '0) begin failures++; $display("FAIL reset_mem_cmd: got %b/%h expected 0/0", mem_cmd_enable, mem_cmd_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    req_cmd_enable = '0;
    cyc(); reset_n = 1'b1;
  endtask

  task automatic test_write();
    logic [CW-1:0] want_cmd;
    logic [MW-1:0] w;
    want_cmd = {1'b0, 32'h10, 32'd4};
    req_wr_data = {N{32'hDEAD_0000}};
    cyc(); set_cmd(1, 1'b0, 32'h10, 32'd4); req_cmd_enable = 4'b0010; #1;
    checks++; if (req_cmd_ready !== 4'b0010) begin failures++; $display("FAIL wr_grant: got %b expected 0010", req_cmd_ready); end
    cyc(); req_cmd_enable = '0; req_wr_enable = '1; #1;
    checks++; if (mem_cmd_enable !== 1'b1 || mem_cmd_data !== want_cmd) begin failures++; $display("FAIL wr_issue: got %b/%h expected 1/%h", mem_cmd_enable, mem_cmd_data, want_cmd); end
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL wr_busy_gid: got %b/%0d expected 1/1", busy, grant_id); end
    checks++; if (mem_wr_enable !== 1'b0 || req_wr_ready !== '0) begin failures++; $display("FAIL wr_path_in_issue: got %b/%b expected 0/0000", mem_wr_enable, req_wr_ready); end
    for (int k = 0; k < 4; k++) begin
      w = 32'hA000_0000 + k;
      cyc(); req_wr_data[1*MW +: MW] = w; #1;
      checks++; if (mem_wr_enable !== 1'b1 || mem_wr_data !== w) begin failures++; $display("FAIL wr_word%0d: got %b/%h expected 1/%h", k, mem_wr_enable, mem_wr_data, w); end
      checks++; if (req_wr_ready !== 4'b0010) begin failures++; $display("FAIL wr_ready%0d: got %b expected 0010", k, req_wr_ready); end
    end
    cyc(); req_wr_enable = '0; #1;
    checks++; if (busy !== 1'b0 || mem_wr_enable !== 1'b0) begin failures++; $display("FAIL wr_end_idle: got busy=%b wr_en=%b expected 0/0", busy, mem_wr_enable); end
  endtask

  task automatic test_read();
    logic [CW-1:0] want_cmd;
    want_cmd = {1'b1, 32'h10, 32'd4};
    cyc(); set_cmd(2, 1'b1, 32'h10, 32'd4); req_cmd_enable = 4'b0100; #1;
    checks++; if (req_cmd_ready !== 4'b0100) begin failures++; $display("FAIL rd_grant: got %b expected 0100", req_cmd_ready); end
    cyc(); req_cmd_enable = '0; mem_rd_enable = 1'b1; mem_rd_data = 32'h5555_5555; req_rd_ready = '1; #1;
    checks++; if (mem_cmd_enable !== 1'b1 || mem_cmd_data !== want_cmd) begin failures++; $display("FAIL rd_issue: got %b/%h expected 1/%h", mem_cmd_enable, mem_cmd_data, want_cmd); end
    checks++; if (mem_rd_ready !== 1'b0 || req_rd_enable !== '0) begin failures++; $display("FAIL rd_outside_read: got %b/%b expected 0/0000", mem_rd_ready, req_rd_enable); end
    for (int k = 0; k < 4; k++) begin
      cyc(); mem_rd_data = mem_img[8'h10 + k]; #1;
      checks++; if (req_rd_enable !== 4'b0100 || mem_rd_ready !== 1'b1) begin failures++; $display("FAIL rd_en%0d: got %b/%b expected 0100/1", k, req_rd_enable, mem_rd_ready); end
      checks++; if (req_rd_data !== 32'hA000_0000 + k) begin failures++; $display("FAIL rd_data%0d: got %h expected %h", k, req_rd_data, 32'hA000_0000 + k); end
    end
    cyc(); mem_rd_enable = 1'b0; #1;
    checks++; if (busy !== 1'b0 || req_rd_enable !== '0) begin failures++; $display("FAIL rd_end_idle: got %b/%b expected 0/0000", busy, req_rd_enable); end
  endtask

  task automatic test_zero_length();
    cyc(); set_cmd(3, 1'b0, 32'h80, 32'd0); req_cmd_enable = 4'b1000; #1;
    checks++; if (req_cmd_ready !== 4'b1000 || busy !== 1'b0) begin failures++; $display("FAIL zl_grant: got %b/%b expected 1000/0", req_cmd_ready, busy); end
    cyc(); req_cmd_enable = '0; #1;
    checks++; if (mem_cmd_enable !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd3) begin failures++; $display("FAIL zl_no_issue: got %b/%b/%0d expected 0/0/3", mem_cmd_enable, busy, grant_id); end
    cyc(); #1;
    checks++; if (mem_cmd_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zl_still_idle: got %b/%b expected 0/0", mem_cmd_enable, busy); end
  endtask

  task automatic test_round_robin();
    int           order [5];
    logic [N-1:0] en, want;
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 32'h100 + i, 32'd1);
    en = '1; mem_rd_enable = 1'b1; req_rd_ready = '1;
    for (int n = 0; n < 5; n++) begin
      want = '0; want[order[n]] = 1'b1;
      cyc(); req_cmd_enable = en; #1;
      checks++; if (req_cmd_ready !== want) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_cmd_ready, want); end
      en[order[n]] = 1'b0;
      if (order[n] == 3) en[0] = 1'b1;
      cyc(); req_cmd_enable = en; mem_rd_data = 32'hC000_0000 + n; #1;
      checks++; if (mem_cmd_enable !== 1'b1 || mem_cmd_data[63:32] !== 32'h100 + order[n] || req_cmd_ready !== '0) begin failures++; $display("FAIL rr_issue%0d: got %b/%h/%b expected 1/%h/0000", n, mem_cmd_enable, mem_cmd_data[63:32], req_cmd_ready, 32'h100 + order[n]); end
      cyc(); #1;
      checks++; if (req_rd_enable !== want || req_rd_data !== 32'hC000_0000 + n) begin failures++; $display("FAIL rr_read%0d: got %b/%h expected %b/%h", n, req_rd_enable, req_rd_data, want, 32'hC000_0000 + n); end
    end
    cyc(); req_cmd_enable = '0; mem_rd_enable = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_end_idle: got %b expected 0", busy); end
  endtask

  task automatic test_wr_backpressure();
    logic [3:0] pat;
    int idx, c, base;
    logic ok;
    pat = 4'b1001; idx = 0; c = 0;
    req_wr_data = {N{32'hDEAD_0000}};
    cyc(); set_cmd(3, 1'b0, 32'h40, 32'd8); req_cmd_enable = 4'b1000; #1;
    checks++; if (req_cmd_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant: got %b expected 1000", req_cmd_ready); end
    cyc(); req_cmd_enable = '0; req_wr_enable = 4'b1000; #1;
    base = wr_count;
    while (idx < 8 && c < 40) begin
      cyc(); mem_wr_ready = pat[c % 4]; req_wr_data[3*MW +: MW] = 32'hB000_0000 + idx; #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_c%0d: got %b expected 1", c, busy); end
      checks++; if (mem_wr_enable !== 1'b1 || mem_wr_data !== 32'hB000_0000 + idx) begin failures++; $display("FAIL bp_word_c%0d: got %b/%h expected 1/%h", c, mem_wr_enable, mem_wr_data, 32'hB000_0000 + idx); end
      checks++; if (req_wr_ready !== {mem_wr_ready, 3'b000}) begin failures++; $display("FAIL bp_ready_c%0d: got %b expected %b", c, req_wr_ready, {mem_wr_ready, 3'b000}); end
      if (req_wr_ready[3]) idx++;
      c++;
    end
    checks++; if (idx != 8) begin failures++; $display("FAIL bp_timeout: got %0d words expected 8", idx); end
    cyc(); mem_wr_ready = 1'b1; req_wr_enable = '0; #1;
    checks++; if (busy !== 1'b0 || wr_count - base != 8) begin failures++; $display("FAIL bp_end: got busy=%b transfers=%0d expected 0/8", busy, wr_count - base); end
    ok = 1'b1;
    for (int k = 0; k < 8; k++) if (mem_img[8'h40 + k] !== 32'hB000_0000 + k) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_mem_image: got %h..%h expected b0000000..b0000007", mem_img[8'h40], mem_img[8'h47]); end
  endtask

  task automatic test_reset_mid_burst();
    cyc(); set_cmd(1, 1'b0, 32'h200, 32'd8); req_cmd_enable = 4'b0010; #1;
    checks++; if (req_cmd_ready !== 4'b0010) begin failures++; $display("FAIL rst_grant: got %b expected 0010", req_cmd_ready); end
    cyc(); req_cmd_enable = '0; req_wr_enable = 4'b0010; mem_wr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); req_wr_data[1*MW +: MW] = 32'hE000_0000 + k;
    end
    #1;
    checks++; if (mem_wr_enable !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre_active: got %b/%b expected 1/1", mem_wr_enable, busy); end
    reset_n = 1'b0; #1;
    checks++; if ({req_cmd_ready, req_wr_ready, req_rd_enable, req_rd_data, mem_cmd_enable, mem_cmd_data,
                   mem_wr_enable, mem_wr_data, mem_rd_ready, busy, grant_id} !== '0) begin
      failures++; $display("FAIL rst_async_outputs: got busy=%b wr_en=%b wr_rdy=%b gid=%0d cmd=%h expected all 0", busy, mem_wr_enable, req_wr_ready, grant_id, mem_cmd_data);
    end
    req_wr_enable = '0;
    cyc(); cyc(); reset_n = 1'b1;
    cyc(); set_cmd(1, 1'b0, 32'h300, 32'd0); set_cmd(3, 1'b0, 32'h300, 32'd0); req_cmd_enable = 4'b1010; #1;
    checks++; if (req_cmd_ready !== 4'b0010) begin failures++; $display("FAIL rst_rr_from0: got %b expected 0010", req_cmd_ready); end
    cyc(); req_cmd_enable = '0; #1;
    checks++; if (grant_id !== 2'd1 || busy !== 1'b0) begin failures++; $display("FAIL rst_after_grant: got %0d/%b expected 1/0", grant_id, busy); end
  endtask

  task automatic test_priority();
    int           seq [4];
    logic [N-1:0] want;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    seq = '{0, 0, 0, 0};
`else
    seq = '{2, 0, 2, 0};
`endif
    set_cmd(0, 1'b0, 32'h400, 32'd0); set_cmd(2, 1'b0, 32'h400, 32'd0);
    for (int n = 0; n < 4; n++) begin
      want = '0; want[seq[n]] = 1'b1;
      cyc(); req_cmd_enable = 4'b0101; #1;
      checks++; if (req_cmd_ready !== want) begin failures++; $display("FAIL pri_grant%0d: got %b expected %b", n, req_cmd_ready, want); end
    end
    cyc(); req_cmd_enable = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_zero_length();
    test_round_robin();
    test_wr_backpressure();
    test_reset_mid_burst();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
